uart_transmitter: RTL and testbench

- Serializes bytes onto the single-wire link consumed by uart_receiver; it is the transmit end of the same rts/serial handshake.
- Accepts bytes from the local fabric through a valid/ready port into a one-entry holding register.
- Starts a frame only when the far receiver's rts (our cts) is high.
- Frame: start symbol (low), 8 data bits MSB first, stop symbol (high). Each symbol lasts SYMBOL_EDGE_TIME clocks.

---
 rtl/uart_transmitter_if.sv | 24 ++
 rtl/uart_transmitter.sv | 139 +++++++++++++
 tb/tb_uart_transmitter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter_if
// Brief    : Byte-stream valid/ready port feeding the UART transmitter.
// Revision : 1.0
// ============================================================================
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Brief    : cts-gated serializer: start(0), 8 data bits MSB first, stop(1).
//            Optional macro UART_TX_BYTE_COUNT_EN adds the tx_count output.
// Revision : 1.0
// ============================================================================
module uart_transmitter #(
  parameter int SYMBOL_EDGE_TIME = 868
) (
  input  wire logic         clock,
  input  wire logic         reset,
  uart_transmitter_if.slave data_port,
  output logic              serial_out,
  input  wire logic         cts,
  output logic              tx_busy
`ifdef UART_TX_BYTE_COUNT_EN
  ,
  output logic [31:0]       tx_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [31:0] c_last_tick = 32'(SYMBOL_EDGE_TIME - 1);

  state_t      r_state;
  logic [31:0] r_tick_ctr;
  logic [7:0]  r_hold;
  logic        r_ready;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_pos;
  logic        r_serial;
  logic        r_busy;
  logic        w_sym_end;

  assign w_sym_end               = (r_tick_ctr == c_last_tick);
  assign serial_out              = r_serial;
  assign tx_busy                 = r_busy;
  assign data_port.data_in_ready = r_ready;

  // r_ready doubles as the "holding register empty" flag; accept needs it
  // high and transfer needs it low, so they can never collide on one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tick_ctr <= '0;
      r_hold     <= '0;
      r_ready    <= 1'b1;
      r_shift    <= '0;
      r_bit_pos  <= 3'd7;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      if (data_port.data_in_valid && r_ready) begin
        r_hold  <= data_port.data_in;
        r_ready <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_tick_ctr <= '0;
          if (!r_ready && cts) begin
            r_shift   <= r_hold;
            r_ready   <= 1'b1;
            r_bit_pos <= 3'd7;
            r_serial  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_START;
          end
        end

        ST_START: begin
          if (w_sym_end) begin
            r_tick_ctr <= '0;
            r_serial   <= r_shift[7];
            r_state    <= ST_DATA;
          end else begin
            r_tick_ctr <= r_tick_ctr + 32'd1;
          end
        end

        ST_DATA: begin
          if (w_sym_end) begin
            r_tick_ctr <= '0;
            if (r_bit_pos == 3'd0) begin
              r_serial <= 1'b1;
              r_state  <= ST_STOP;
            end else begin
              // Present the next bit on the same edge the counter wraps.
              r_bit_pos <= r_bit_pos - 3'd1;
              r_serial  <= r_shift[r_bit_pos - 3'd1];
            end
          end else begin
            r_tick_ctr <= r_tick_ctr + 32'd1;
          end
        end

        ST_STOP: begin
          if (w_sym_end) begin
            r_tick_ctr <= '0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_tick_ctr <= r_tick_ctr + 32'd1;
          end
        end

        default: begin
          r_tick_ctr <= '0;
          r_serial   <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_BYTE_COUNT_EN
  logic [31:0] r_tx_count;

  assign tx_count = r_tx_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_count <= '0;
    end else if ((r_state == ST_STOP) && w_sym_end) begin
      r_tx_count <= r_tx_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Brief    : Self-checking bench: table of frames, hand sequences, random
//            traffic against a cycle-level reference model (two symbol times).
// Revision : 1.0
// ============================================================================
module tb_uart_transmitter;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       cts       = 1'b0;
  logic       sel       = 1'b0;   // 0: SYMBOL_EDGE_TIME=4, 1: SYMBOL_EDGE_TIME=2
  logic [7:0] drv_data  = 8'h00;
  logic       drv_valid = 1'b0;
  int         errors    = 0;
  int         checks    = 0;

  always #5 clk = ~clk;

  uart_transmitter_if bus4 ();
  uart_transmitter_if bus2 ();

  assign bus4.data_in       = drv_data;
  assign bus4.data_in_valid = drv_valid && !sel;
  assign bus2.data_in       = drv_data;
  assign bus2.data_in_valid = drv_valid && sel;

  logic serial4, busy4, serial2, busy2;
  logic cur_serial, cur_busy, cur_ready;

  always_comb begin
    cur_serial = sel ? serial2 : serial4;
    cur_busy   = sel ? busy2 : busy4;
    cur_ready  = sel ? bus2.data_in_ready : bus4.data_in_ready;
  end

`ifdef UART_TX_BYTE_COUNT_EN
  logic [31:0] count4, count2, cur_count;
  always_comb cur_count = sel ? count2 : count4;
`endif

  uart_transmitter #(.SYMBOL_EDGE_TIME(4)) dut4 (
    .clock      (clk),
    .reset      (reset),
    .data_port  (bus4),
    .serial_out (serial4),
    .cts        (cts),
    .tx_busy    (busy4)
`ifdef UART_TX_BYTE_COUNT_EN
    ,
    .tx_count   (count4)
`endif
  );

  uart_transmitter #(.SYMBOL_EDGE_TIME(2)) dut2 (
    .clock      (clk),
    .reset      (reset),
    .data_port  (bus2),
    .serial_out (serial2),
    .cts        (cts),
    .tx_busy    (busy2)
`ifdef UART_TX_BYTE_COUNT_EN
    ,
    .tx_count   (count2)
`endif
  );

  // Reference model: frame position in cycles (-1 = idle), plus a one-byte hold.
  int         m_frame  = -1;
  logic [7:0] m_cur    = 8'h00;
  logic [7:0] m_hold   = 8'h00;
  logic       m_full   = 1'b0;
  int         m_count4 = 0;
  int         m_count2 = 0;
  int         m_s;

  always_comb m_s = sel ? 2 : 4;

  function automatic logic exp_line(input int f, input logic [7:0] d, input int s);
    int idx;
    if (f < 0) return 1'b1;
    idx = f / s;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[8 - idx];
  endfunction

  initial forever begin
    logic acc;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_frame  = -1;
      m_full   = 1'b0;
      m_count4 = 0;
      m_count2 = 0;
    end else begin
      acc = drv_valid && !m_full;
      if (m_frame >= 0) begin
        if (m_frame == 10 * m_s - 1) begin
          m_frame = -1;
          if (sel) m_count2++;
          else     m_count4++;
        end else begin
          m_frame++;
        end
      end else if (m_full && cts) begin
        m_frame = 0;
        m_cur   = m_hold;
        m_full  = 1'b0;
      end
      if (acc) begin
        m_hold = drv_data;
        m_full = 1'b1;
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  initial forever begin
    logic es, eb, er;
    @(negedge clk);
    es = exp_line(m_frame, m_cur, m_s);
    eb = (m_frame >= 0);
    er = !m_full;
    checks++;
    if ({cur_serial, cur_busy, cur_ready} !== {es, eb, er}) begin
      errors++;
      $display("FAIL model_cycle t=%0t sel=%0d serial/busy/ready actual=%b%b%b expected=%b%b%b",
               $time, sel, cur_serial, cur_busy, cur_ready, es, eb, er);
    end
`ifdef UART_TX_BYTE_COUNT_EN
    checks++;
    if (cur_count !== 32'(sel ? m_count2 : m_count4)) begin
      errors++;
      $display("FAIL model_count t=%0t actual=%0d expected=%0d",
               $time, cur_count, sel ? m_count2 : m_count4);
    end
`endif
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cur_busy == 1'b0 && cur_ready == 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("wait_idle_timeout", n, 0);
  endtask

  // Push one byte, optionally hold cts low for cts_wait cycles, then check
  // start latency, each of the 10 symbols and the busy duration.
  task automatic run_frame(input logic [7:0] d, input int s, input int cts_wait,
                           input logic [9:0] frame, input int exp_lat);
    int   lat;
    int   bad_idle;
    int   busy_n;
    logic sym_ok;
    wait_idle();
    cts       = (cts_wait == 0);
    drv_data  = d;
    drv_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drv_valid = 1'b0;
    drv_data  = 8'($urandom);
    if (cts_wait > 0) begin
      bad_idle = 0;
      for (int i = 0; i < cts_wait; i++) begin
        if (cur_serial !== 1'b1 || cur_ready !== 1'b0) bad_idle++;
        @(negedge clk);
        lat++;
      end
      check("cts_low_hold", bad_idle, 0);
      cts = 1'b1;
    end
    while (cur_serial === 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", lat, exp_lat);
    busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      sym_ok = 1'b1;
      for (int j = 0; j < s; j++) begin
        if (cur_serial !== frame[9 - k]) sym_ok = 1'b0;
        if (cur_busy === 1'b1) busy_n++;
        @(negedge clk);
      end
      check($sformatf("symbol%0d_of_%02h", k, d), int'(sym_ok), 1);
    end
    check("busy_len", busy_n, 10 * s);
    check("busy_clear", int'(cur_busy), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       s2;
    int         cts_wait;
    logic [9:0] frame;
    int         lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int   n;
    int   gap;
    int   rdy_bad;
    logic [7:0] bytes [7] = '{8'h5A, 8'hA5, 8'h00, 8'h80, 8'hFF, 8'hC3, 8'h01};
    logic       sels  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int         waits [7] = '{0, 0, 0, 0, 3, 5, 0};

    for (int i = 0; i < 7; i++) begin
      tbl[i].data     = bytes[i];
      tbl[i].s2       = sels[i];
      tbl[i].cts_wait = waits[i];
      tbl[i].frame    = {1'b0, bytes[i], 1'b1};
      tbl[i].lat      = 2 + waits[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_serial", int'(cur_serial), 1);
    check("reset_busy", int'(cur_busy), 0);
    check("reset_ready", int'(cur_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: second byte accepted while the first is in DATA
    cts       = 1'b1;
    drv_data  = 8'h01;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b_ready_mid_frame", int'(cur_ready), 1);
    drv_data  = 8'hFF;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    check("b2b_hold_full", int'(cur_ready), 0);
    n = 0;
    rdy_bad = 0;
    while (cur_busy === 1'b1 && n < 200) begin
      if (cur_ready !== 1'b0) rdy_bad++;
      @(negedge clk);
      n++;
    end
    check("b2b_ready_low_in_frame", rdy_bad, 0);
    gap = 0;
    while (cur_serial === 1'b1 && gap < 200) begin
      if (cur_ready !== 1'b0) rdy_bad++;
      @(negedge clk);
      gap++;
    end
    check("b2b_idle_gap", gap, 1);
    check("b2b_ready_until_start", rdy_bad, 0);
    check("b2b_ready_after_start", int'(cur_ready), 1);
    wait_idle();

    // Flow control: cts low for 100 cycles
    run_frame(8'h3C, 4, 100, {1'b0, 8'h3C, 1'b1}, 102);

`ifdef UART_TX_BYTE_COUNT_EN
    check("count_before_reset", int'(cur_count), 3);
`endif

    // Asynchronous reset during DATA bit 3 of the fourth frame
    wait_idle();
    cts       = 1'b1;
    drv_data  = 8'hC3;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    n = 0;
    while (cur_serial === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (21) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_serial", int'(cur_serial), 1);
    check("async_rst_busy", int'(cur_busy), 0);
    check("async_rst_ready", int'(cur_ready), 1);
`ifdef UART_TX_BYTE_COUNT_EN
    check("count_after_reset", int'(cur_count), 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table of frames across both symbol times
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      #1 sel = tbl[i].s2;
      @(negedge clk);
      run_frame(tbl[i].data, tbl[i].s2 ? 2 : 4, tbl[i].cts_wait, tbl[i].frame, tbl[i].lat);
    end

    // Random traffic on both instances, checked cycle by cycle by the model
    for (int r = 0; r < 2; r++) begin
      wait_idle();
      #1 sel = (r == 1);
      @(negedge clk);
      for (int c = 0; c < 1500; c++) begin
        drv_valid = ($urandom_range(0, 3) == 0);
        drv_data  = 8'($urandom);
        cts       = ($urandom_range(0, 4) != 0);
        @(negedge clk);
      end
      drv_valid = 1'b0;
      cts       = 1'b1;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
